// File: rtl/pipe_ctrl_unit_if.sv
// pipe_ctrl_unit_if: request/response bundle between the pipeline and its stall/flush controller.
interface pipe_ctrl_unit_if #(
    parameter int NSTAGE = 5,
    parameter int LEN_W  = 6,
    parameter int PERF_W = 32,
    parameter int SW     = $clog2(NSTAGE)
);
    logic [NSTAGE-1:0] stallreq;
    logic              mc_start;
    logic [SW-1:0]     mc_stage;
    logic [LEN_W-1:0]  mc_len;
    logic              mc_abort;
    logic              flush_req;
    logic [SW-1:0]     flush_stage;
    logic [NSTAGE-1:0] stall;
    logic [NSTAGE-1:0] bubble;
    logic [NSTAGE-1:0] flush;
    logic              mc_busy;
    logic [PERF_W-1:0] perf_stall_cnt;

    modport master (
        output stallreq, mc_start, mc_stage, mc_len, mc_abort, flush_req, flush_stage,
        input  stall, bubble, flush, mc_busy, perf_stall_cnt
    );
    modport slave (
        input  stallreq, mc_start, mc_stage, mc_len, mc_abort, flush_req, flush_stage,
        output stall, bubble, flush, mc_busy, perf_stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: merges per-stage stalls, a counted multi-cycle stall and an exception flush
// into per-stage stall/bubble/flush vectors, plus a saturating stall-cycle counter.
module pipe_ctrl_unit #(
    parameter int NSTAGE = 5,
    parameter int LEN_W  = 6,
    parameter int PERF_W = 32,
    parameter int SW     = $clog2(NSTAGE)
) (
    input logic cpu_clk_50M,
    input logic cpu_rst,
    pipe_ctrl_unit_if.slave bus
);
    logic [LEN_W-1:0]  mc_cnt;
    logic [SW-1:0]     mc_own;
    logic [PERF_W-1:0] perf;
    logic              mc_busy, mc_new, mc_act, mc_kill;
    logic [SW-1:0]     mc_stg;
    logic [NSTAGE-1:0] req, st, bb, fl, stall_v;

    assign mc_busy = mc_cnt != '0;
    assign mc_new  = bus.mc_start & ~mc_busy & (bus.mc_len != '0) & ~bus.mc_abort;
    assign mc_act  = (mc_busy & ~bus.mc_abort) | mc_new;
    assign mc_stg  = mc_busy ? mc_own : bus.mc_stage;
    // A flush at or above the owning stage squashes the multi-cycle op, including one starting now
    assign mc_kill = (bus.flush_req && bus.flush_stage >= mc_stg) || bus.mc_abort;

    // Every stage at or below the highest requester holds; the stage just above takes a bubble
    always_comb begin
        req = bus.stallreq | (NSTAGE'(mc_act) << mc_stg);
        for (int i = 0; i < NSTAGE; i++) st[i] = |(req >> i);
        bb[0] = 1'b0;
        for (int i = 1; i < NSTAGE; i++) bb[i] = st[i-1] & ~st[i];
        for (int i = 0; i < NSTAGE; i++) fl[i] = bus.flush_req & (SW'(i) <= bus.flush_stage);
    end

    assign stall_v            = (cpu_rst | bus.flush_req) ? '0 : st;
    assign bus.stall          = stall_v;
    assign bus.bubble         = (cpu_rst | bus.flush_req) ? '0 : bb;
    assign bus.flush          = cpu_rst ? '0 : fl;
    assign bus.mc_busy        = mc_busy;
    assign bus.perf_stall_cnt = perf;

    always_ff @(posedge cpu_clk_50M or posedge cpu_rst)
        if (cpu_rst) begin
            mc_cnt <= '0;
            mc_own <= '0;
            perf   <= '0;
        end else begin
            if (mc_kill) mc_cnt <= '0;
            else if (mc_new) begin
                mc_cnt <= bus.mc_len - LEN_W'(1);
                mc_own <= bus.mc_stage;
            end else if (mc_busy) mc_cnt <= mc_cnt - LEN_W'(1);
            if (stall_v[0] && !(&perf)) perf <= perf + PERF_W'(1);
        end
endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: vector table plus multi-cycle sequences, checked through an expectation queue.
module tb_pipe_ctrl_unit;
    logic cpu_clk_50M = 1'b0;
    logic cpu_rst = 1'b1;
    int n_chk = 0, n_fail = 0;

    always #10 cpu_clk_50M = ~cpu_clk_50M;

    pipe_ctrl_unit_if #(.NSTAGE(5), .LEN_W(6), .PERF_W(4)) bus ();
    pipe_ctrl_unit #(.NSTAGE(5), .LEN_W(6), .PERF_W(4)) dut (
        .cpu_clk_50M(cpu_clk_50M),
        .cpu_rst(cpu_rst),
        .bus(bus)
    );

    typedef struct {
        string      nm;
        logic       r;
        logic [4:0] sr;
        logic       ms;
        logic [2:0] stg;
        logic [5:0] len;
        logic       ab;
        logic       fr;
        logic [2:0] fs;
        logic [4:0] st, bb, fl;
        logic       busy;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[8];

    function automatic vec_t v(string nm, logic r, logic [4:0] sr, logic ms, logic [2:0] stg,
                               logic [5:0] len, logic ab, logic fr, logic [2:0] fs,
                               logic [4:0] st, logic [4:0] bb, logic [4:0] fl, logic busy);
        vec_t x;
        x.nm = nm; x.r = r; x.sr = sr; x.ms = ms; x.stg = stg; x.len = len; x.ab = ab;
        x.fr = fr; x.fs = fs; x.st = st; x.bb = bb; x.fl = fl; x.busy = busy;
        return x;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(vec_t x);
        vec_t e;
        @(posedge cpu_clk_50M);
        #1;
        cpu_rst = x.r;
        bus.stallreq = x.sr; bus.mc_start = x.ms; bus.mc_stage = x.stg; bus.mc_len = x.len;
        bus.mc_abort = x.ab; bus.flush_req = x.fr; bus.flush_stage = x.fs;
        sb.push_back(x);
        @(negedge cpu_clk_50M);
        if (sb.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard: got empty queue expected entry");
        end else begin
            e = sb.pop_front();
            chk({e.nm, " stall"}, 32'(bus.stall), 32'(e.st));
            chk({e.nm, " bubble"}, 32'(bus.bubble), 32'(e.bb));
            chk({e.nm, " flush"}, 32'(bus.flush), 32'(e.fl));
            chk({e.nm, " mc_busy"}, 32'(bus.mc_busy), 32'(e.busy));
        end
    endtask

    task automatic idle(string nm, logic [4:0] st, logic [4:0] bb, logic busy);
        step(v(nm, 0, 0, 0, 0, 0, 0, 0, 0, st, bb, 0, busy));
    endtask

    initial begin
        bus.stallreq = '0; bus.mc_start = 0; bus.mc_stage = '0; bus.mc_len = '0;
        bus.mc_abort = 0; bus.flush_req = 0; bus.flush_stage = '0;

        tbl[0] = v("sr00100",   0, 5'b00100, 0, 0, 0, 0, 0, 0, 5'b00111, 5'b01000, 5'b00000, 0);
        tbl[1] = v("sr_none",   0, 5'b00000, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 5'b00000, 0);
        tbl[2] = v("sr10000",   0, 5'b10000, 0, 0, 0, 0, 0, 0, 5'b11111, 5'b00000, 5'b00000, 0);
        tbl[3] = v("sr00001",   0, 5'b00001, 0, 0, 0, 0, 0, 0, 5'b00001, 5'b00010, 5'b00000, 0);
        tbl[4] = v("sr01010",   0, 5'b01010, 0, 0, 0, 0, 0, 0, 5'b01111, 5'b10000, 5'b00000, 0);
        tbl[5] = v("flush3",    0, 5'b00100, 0, 0, 0, 0, 1, 3, 5'b00000, 5'b00000, 5'b01111, 0);
        tbl[6] = v("flush0",    0, 5'b00000, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b00000, 5'b00001, 0);
        tbl[7] = v("flush4",    0, 5'b11111, 0, 0, 0, 0, 1, 4, 5'b00000, 5'b00000, 5'b11111, 0);

        // Outputs forced low while reset is held, even with requests present
        step(v("in_reset", 1, 5'b11111, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0));
        idle("post_reset", 0, 0, 0);
        chk("perf_after_reset", 32'(bus.perf_stall_cnt), 0);

        foreach (tbl[i]) step(tbl[i]);
        idle("after_table", 0, 0, 0);
        chk("perf_table", 32'(bus.perf_stall_cnt), 4);

        // mc_len=4 at stage 2; a second start while busy is ignored
        step(v("mc_c1", 0, 0, 1, 2, 4, 0, 0, 0, 5'b00111, 5'b01000, 0, 0));
        step(v("mc_c2", 0, 0, 1, 4, 9, 0, 0, 0, 5'b00111, 5'b01000, 0, 1));
        idle("mc_c3", 5'b00111, 5'b01000, 1);
        idle("mc_c4", 5'b00111, 5'b01000, 1);
        idle("mc_c5", 0, 0, 0);

        // Flush above the owner kills the operation
        step(v("fh_start", 0, 0, 1, 2, 5, 0, 0, 0, 5'b00111, 5'b01000, 0, 0));
        step(v("fh_flush", 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 5'b01111, 1));
        idle("fh_after", 0, 0, 0);

        // Flush below the owner: stall resumes, then abort cancels it
        step(v("fl_start", 0, 0, 1, 2, 5, 0, 0, 0, 5'b00111, 5'b01000, 0, 0));
        step(v("fl_flush", 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 5'b00011, 1));
        idle("fl_resume", 5'b00111, 5'b01000, 1);
        step(v("fl_abort", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
        idle("fl_after", 0, 0, 0);

        // Stallreq above an active multi-cycle stall; releasing one keeps the other
        step(v("cb_start", 0, 5'b10000, 1, 1, 6, 0, 0, 0, 5'b11111, 0, 0, 0));
        step(v("cb_both", 0, 5'b10000, 0, 0, 0, 0, 0, 0, 5'b11111, 0, 0, 1));
        idle("cb_mc_only", 5'b00011, 5'b00100, 1);
        step(v("cb_abort", 0, 5'b10000, 0, 0, 0, 1, 0, 0, 5'b11111, 0, 0, 1));
        idle("cb_after", 0, 0, 0);

        step(v("len1", 0, 0, 1, 3, 1, 0, 0, 0, 5'b01111, 5'b10000, 0, 0));
        idle("len1_after", 0, 0, 0);
        step(v("len0", 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0));
        idle("len0_after", 0, 0, 0);

        // Asynchronous reset in the middle of a run with mc_cnt=3
        step(v("rs_start", 0, 0, 1, 2, 6, 0, 0, 0, 5'b00111, 5'b01000, 0, 0));
        idle("rs_c2", 5'b00111, 5'b01000, 1);
        idle("rs_c3", 5'b00111, 5'b01000, 1);
        step(v("rs_assert", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        idle("rs_release", 0, 0, 0);
        chk("perf_rs", 32'(bus.perf_stall_cnt), 0);

        // Saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            step(v("sat", 0, 5'b00001, 0, 0, 0, 0, 0, 0, 5'b00001, 5'b00010, 0, 0));
            chk("perf_sat", 32'(bus.perf_stall_cnt), (i < 15) ? i : 15);
        end
        idle("sat_end", 0, 0, 0);
        chk("perf_final", 32'(bus.perf_stall_cnt), 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
